// File: rtl/bresenham_pkg.sv
// Shared types and sizing helpers for the streaming Bresenham line engine.
package bresenham_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_COORD_W = 8;

    // Signed width that holds dx, dy, err and 2*err for a given coordinate width.
    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham step: given the current point and error term, produce the
// next point and error term. Purely combinational.
module bresenham_step
    import bresenham_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic [COORD_W-1:0]                      i_cur_x,
    input  logic [COORD_W-1:0]                      i_cur_y,
    input  logic signed [err_width(COORD_W)-1:0]    i_err,
    input  logic signed [err_width(COORD_W)-1:0]    i_dx,
    input  logic signed [err_width(COORD_W)-1:0]    i_dy,
    input  logic                                    i_sx_neg,
    input  logic                                    i_sy_neg,
    output logic [COORD_W-1:0]                      o_next_x,
    output logic [COORD_W-1:0]                      o_next_y,
    output logic signed [err_width(COORD_W)-1:0]    o_next_err
);

    localparam int EW = err_width(COORD_W);
    localparam logic [COORD_W-1:0] ONE = 1;

    logic signed [EW-1:0] w_e2;
    logic                 w_step_x;
    logic                 w_step_y;

    // Both decisions look at the error term before this step is applied.
    assign w_e2     = i_err <<< 1;
    assign w_step_x = (w_e2 >= i_dy);
    assign w_step_y = (w_e2 <= i_dx);

    // Apply the x and/or y advance and accumulate the matching error deltas.
    always_comb begin
        o_next_x   = i_cur_x;
        o_next_y   = i_cur_y;
        o_next_err = i_err;
        if (w_step_x) begin
            o_next_err = o_next_err + i_dy;
            o_next_x   = i_sx_neg ? (i_cur_x - ONE) : (i_cur_x + ONE);
        end
        if (w_step_y) begin
            o_next_err = o_next_err + i_dx;
            o_next_y   = i_sy_neg ? (i_cur_y - ONE) : (i_cur_y + ONE);
        end
    end

endmodule

// File: rtl/bresenham_stream.sv
// Streaming Bresenham line engine: one segment per command, one pixel beat
// per accepted valid/ready handshake, all eight octants.
// Optional screen clipping is enabled by defining BRESENHAM_STREAM_CLIP_EN;
// off-screen pixels are then walked internally without emitting a beat.
module bresenham_stream
    import bresenham_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 64
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               px_last,
    output logic               done
);

    localparam int EW = err_width(COORD_W);
`ifdef BRESENHAM_STREAM_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif
    localparam logic [31:0] SCREEN_W_U = SCREEN_W;
    localparam logic [31:0] SCREEN_H_U = SCREEN_H;

    state_t               r_state;
    logic [COORD_W-1:0]   r_cur_x;
    logic [COORD_W-1:0]   r_cur_y;
    logic [COORD_W-1:0]   r_end_x;
    logic [COORD_W-1:0]   r_end_y;
    logic signed [EW-1:0] r_err;
    logic signed [EW-1:0] r_dx;
    logic signed [EW-1:0] r_dy;
    logic                 r_sx_neg;
    logic                 r_sy_neg;

    logic                 w_x_pos;
    logic                 w_y_pos;
    logic [COORD_W-1:0]   w_adx;
    logic [COORD_W-1:0]   w_ady;
    logic signed [EW-1:0] w_setup_dx;
    logic signed [EW-1:0] w_setup_dy;
    logic [COORD_W-1:0]   w_next_x;
    logic [COORD_W-1:0]   w_next_y;
    logic signed [EW-1:0] w_next_err;
    logic                 w_at_end;
    logic                 w_cur_on;
    logic                 w_next_on;
    logic                 w_run;
    logic                 w_advance;

    // Line geometry from the captured endpoints (cur holds the start point in SETUP).
    assign w_x_pos    = (r_cur_x < r_end_x);
    assign w_y_pos    = (r_cur_y < r_end_y);
    assign w_adx      = w_x_pos ? (r_end_x - r_cur_x) : (r_cur_x - r_end_x);
    assign w_ady      = w_y_pos ? (r_end_y - r_cur_y) : (r_cur_y - r_end_y);
    assign w_setup_dx = signed'({2'b00, w_adx});
    assign w_setup_dy = -signed'({2'b00, w_ady});

    bresenham_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .i_cur_x    (r_cur_x),
        .i_cur_y    (r_cur_y),
        .i_err      (r_err),
        .i_dx       (r_dx),
        .i_dy       (r_dy),
        .i_sx_neg   (r_sx_neg),
        .i_sy_neg   (r_sy_neg),
        .o_next_x   (w_next_x),
        .o_next_y   (w_next_y),
        .o_next_err (w_next_err)
    );

    // The walk is monotonic in x and y, so the on-screen pixels form one
    // contiguous run; the last visible pixel is the one whose successor is
    // off-screen (or that is the endpoint itself).
    assign w_at_end  = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);
    assign w_cur_on  = !CLIP || ((32'(r_cur_x) < SCREEN_W_U) && (32'(r_cur_y) < SCREEN_H_U));
    assign w_next_on = !CLIP || ((32'(w_next_x) < SCREEN_W_U) && (32'(w_next_y) < SCREEN_H_U));
    assign w_run     = (r_state == RUN);
    assign w_advance = w_run && (!w_cur_on || px_ready);

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign px_valid = w_run && w_cur_on;
    assign px_last  = px_valid && (w_at_end || !w_next_on);
    assign px_x     = r_cur_x;
    assign px_y     = r_cur_y;

    // Control FSM; abort returns to IDLE from anywhere and beats every other input.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else if (abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) r_state <= SETUP;
                SETUP:   r_state <= RUN;
                RUN:     if (w_advance && w_at_end) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath: capture endpoints, derive deltas, then step on each accepted or skipped pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_end_x  <= '0;
            r_end_y  <= '0;
            r_err    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else if (!abort) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur_x <= x0;
                        r_cur_y <= y0;
                        r_end_x <= x1;
                        r_end_y <= y1;
                    end
                end
                SETUP: begin
                    r_dx     <= w_setup_dx;
                    r_dy     <= w_setup_dy;
                    r_err    <= w_setup_dx + w_setup_dy;
                    r_sx_neg <= !w_x_pos;
                    r_sy_neg <= !w_y_pos;
                end
                RUN: begin
                    if (w_advance && !w_at_end) begin
                        r_cur_x <= w_next_x;
                        r_cur_y <= w_next_y;
                        r_err   <= w_next_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bresenham_stream.md
Name: bresenham_stream

Overview:
Parametrised successor to the fixed-width 8-bit Bresenham line engine.
- Accepts one line segment per command and walks it in all eight octants.
- Emits each pixel as a coordinate beat on a valid/ready stream, instead of writing a fixed 64x64 picture buffer.
- Sits between the command decoder and the frame-buffer writer in the 2D GPU pipeline.

Parameters:
- COORD_W, 8: width of every coordinate, unsigned.
- SCREEN_W, 64: screen width in pixels; used only when CLIP_EN is defined.
- SCREEN_H, 64: screen height in pixels; used only when CLIP_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- abort  in  1  cancel the current line from any state.
- x0  in  COORD_W  start x.
- y0  in  COORD_W  start y.
- x1  in  COORD_W  end x.
- y1  in  COORD_W  end y.
- busy  out  1  high in every state except IDLE.
- px_valid  out  1  pixel beat valid.
- px_ready  in  1  downstream accepts the beat.
- px_x  out  COORD_W  pixel x.
- px_y  out  COORD_W  pixel y.
- px_last  out  1  marks the final emitted pixel of the line.
- done  out  1  one-cycle pulse when the line completes.

Behaviour:
- Reset: the FSM goes to IDLE. busy, px_valid, px_x, px_y, px_last and done are all 0.
- States:
  - IDLE -> SETUP on start. x0..y1 are captured on that clock edge.
  - SETUP -> RUN after 1 cycle. Computes:
    - dx = |x1-x0|, dy = -|y1-y0|
    - sx = +1 if x0<x1, else -1; sy likewise from y0, y1
    - err = dx+dy
    - cur = (x0, y0)
    - Internal signed width is COORD_W+2; e2 = 2*err also fits in COORD_W+2.
  - RUN: px_valid=1, px_x/px_y=cur, px_last=(cur==end).
    - Handshake occurs when px_valid && px_ready.
    - On a handshake with cur==end: -> DONE.
    - On any other handshake, step cur:
      - if e2>=dy: err+=dy, x+=sx
      - if e2<=dx: err+=dx, y+=sy
      - Both conditions are evaluated on the pre-step err. Both updates apply in the same cycle when both hold.
  - DONE: done=1 for exactly 1 cycle, busy=1, -> IDLE.
- Latency and throughput:
  - start sampled in cycle N gives the first px_valid in cycle N+2.
  - Under continuous ready, one pixel per cycle.
  - Beat count is max(dx,|dy|)+1.
- Backpressure: while px_valid && !px_ready, px_x, px_y and px_last hold stable and err does not change.
- Degenerate line (x0==x1 && y0==y1): exactly one beat, with px_last=1.
- start while busy: ignored, with no effect on the current line.
- start in the same cycle DONE->IDLE occurs: not accepted; start must be presented in IDLE.
- abort:
  - Has priority over every other input.
  - Next cycle is IDLE with px_valid=0. No done pulse and no px_last are produced.
  - abort together with start in IDLE: the command is discarded.
- Coordinates are unsigned and never wrap. The walk stays inside the bounding box of the two endpoints.

Optional Feature:
Macro: BRESENHAM_STREAM_CLIP_EN
- Defined:
  - A pixel with x>=SCREEN_W or y>=SCREEN_H is stepped internally in 1 cycle with px_valid=0.
  - px_last is asserted on the last on-screen pixel, detected by lookahead on the remaining path.
  - If no pixel of the line is on screen, no beat is emitted, and done still pulses.
- Not defined: every pixel is emitted. SCREEN_W and SCREEN_H are unused.

Decomposition:
- Package bresenham_pkg holds:
  - typedef enum of states (IDLE, SETUP, RUN, DONE)
  - default COORD_W constant
  - function err_width(COORD_W) = COORD_W+2
- One combinational sub-module, bresenham_step:
  - Inputs: cur, err, dx, dy, sx, sy.
  - Outputs: next cur, next err.
  - Instantiated once; lets the bench test the error update exhaustively.

Test Plan:
1. Gentle line (128,128)->(137,136), ready=1: 10 beats. First (128,128), second (129,129), last (137,136) with px_last=1. done pulses exactly 1 cycle after the last beat.
2. Steep negative line (10,20)->(8,13), ready=1: 8 beats, with y strictly decreasing by 1 per beat and x going 10->8. px_last on (8,13).
3. Degenerate line (5,5)->(5,5): a single beat (5,5) with px_last=1, then done. Total time from start is 4 cycles.
4. Backpressure on (0,0)->(3,0), ready toggled 1,0,0,1,…: beats (0,0),(1,0),(2,0),(3,0) in order. No duplicates and no skips. Outputs stay stable in every ready=0 cycle.
5. abort in the 3rd RUN cycle of (0,0)->(20,20): px_valid falls the next cycle, no done and no px_last. A following start on (1,1)->(2,2) gives 2 correct beats.
6. With CLIP_EN, SCREEN_W=SCREEN_H=64, line (60,60)->(70,70): beats (60,60)..(63,63) only, px_last on (63,63). done pulses after the internal walk reaches (70,70).
